flit_request_generator: RTL and testbench

Clocked, parametrised successor of the two-phase request generator for the MouseTrap router output stage. It takes one upstream two-phase (transition-signalled) flit channel and steers it to one of OUTPORTS downstream two-phase channels. The head flit locks the channel to its destination port (wormhole) until the tail flit has been acknowledged. It also adds U-turn rejection, a per-packet flit counter and sticky protocol-error reporting. All handshake inputs are already synchronised to clk.

---
 rtl/flit_request_generator.sv | 135 +++++++++++++
 tb/tb_flit_request_generator.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/flit_request_generator.sv
// Wormhole request generator for a router output stage. It steers one upstream
// two-phase flit channel to the port named by each head flit.
module flit_request_generator #(
    parameter int OUTPORTS = 4,
    parameter int LOCATION = 0,
    parameter int CNT_W    = 8,
    parameter int PW       = $clog2(OUTPORTS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_up_i,
    input  logic                head_up_i,
    input  logic                tail_up_i,
    input  logic [PW-1:0]       dest_up_i,
    output logic                ack_up_o,
    output logic [OUTPORTS-1:0] req_dw_o,
    input  logic [OUTPORTS-1:0] ack_dw_i,
    output logic                packet_active_o,
    output logic [PW-1:0]       active_port_o,
    output logic [CNT_W-1:0]    flit_cnt_o,
    output logic                err_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCKED   = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    state_t              state;
    logic                req_seen;
    logic [OUTPORTS-1:0] ack_seen;
    logic                cur_tail;
    logic [PW-1:0]       port;

    logic                up_evt;
    logic [OUTPORTS-1:0] dw_evt;
    logic                legal_dest;
    logic [OUTPORTS-1:0] port_mask;
    logic [OUTPORTS-1:0] dest_mask;
    logic                valid_ack;
    logic                spurious_ack;

    function automatic logic [OUTPORTS-1:0] onehot(input logic [PW-1:0] idx);
        return {{(OUTPORTS-1){1'b0}}, 1'b1} << idx;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    always_comb begin
        up_evt       = req_up_i ^ req_seen;
        dw_evt       = ack_dw_i ^ ack_seen;
        legal_dest   = (int'(dest_up_i) != LOCATION) && (int'(dest_up_i) < OUTPORTS);
        port_mask    = onehot(port);
        dest_mask    = onehot(dest_up_i);
        valid_ack    = (state == WAIT_ACK) && (|(dw_evt & port_mask));
        // Anything other than the locked port's ack while waiting is unexpected.
        spurious_ack = |(dw_evt & ~((state == WAIT_ACK) ? port_mask : '0));
    end

    assign active_port_o = port;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            req_seen        <= 1'b0;
            ack_seen        <= '0;
            cur_tail        <= 1'b0;
            port            <= '0;
            ack_up_o        <= 1'b0;
            req_dw_o        <= '0;
            packet_active_o <= 1'b0;
            flit_cnt_o      <= '0;
            err_o           <= 1'b0;
        end else begin
            // Every downstream event, valid or spurious, is consumed exactly once.
            ack_seen <= ack_dw_i;
            if (spurious_ack) begin
                err_o <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (up_evt) begin
                        req_seen <= req_up_i;
                        if (head_up_i && legal_dest) begin
                            port            <= dest_up_i;
                            req_dw_o        <= req_dw_o ^ dest_mask;
                            packet_active_o <= 1'b1;
                            flit_cnt_o      <= '0;
                            cur_tail        <= tail_up_i;
                            state           <= WAIT_ACK;
                        end else begin
                            ack_up_o <= ~ack_up_o;
                            err_o    <= 1'b1;
                        end
                    end
                end

                LOCKED: begin
                    if (up_evt) begin
                        req_seen <= req_up_i;
                        req_dw_o <= req_dw_o ^ port_mask;
                        cur_tail <= tail_up_i;
                        state    <= WAIT_ACK;
                        // A head inside a packet is forwarded as a body flit.
                        if (head_up_i) begin
                            err_o <= 1'b1;
                        end
                    end
                end

                WAIT_ACK: begin
                    if (valid_ack) begin
                        ack_up_o   <= ~ack_up_o;
                        flit_cnt_o <= sat_inc(flit_cnt_o);
                        if (cur_tail) begin
                            packet_active_o <= 1'b0;
                            state           <= IDLE;
                        end else begin
                            state <= LOCKED;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flit_request_generator.sv
// Bench for flit_request_generator: directed packet scenarios followed by random
// traffic, compared against a transaction-level model of the router channel.
module tb_flit_request_generator;

    localparam int OUTPORTS = 4;
    localparam int LOCATION = 0;
    localparam int CNT_W    = 2;
    localparam int PW       = 2;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                req_up;
    logic                head_up;
    logic                tail_up;
    logic [PW-1:0]       dest_up;
    logic                ack_up_o;
    logic [OUTPORTS-1:0] req_dw_o;
    logic [OUTPORTS-1:0] ack_dw;
    logic                packet_active_o;
    logic [PW-1:0]       active_port_o;
    logic [CNT_W-1:0]    flit_cnt_o;
    logic                err_o;

    int checks = 0;
    int errors = 0;

    // Expected channel-level view
    logic                e_ack_up;
    logic [OUTPORTS-1:0] e_req_dw;
    logic                e_active;
    logic [PW-1:0]       e_port;
    int                  e_cnt;
    logic                e_err;
    logic                m_pending;
    logic                m_tail;

    flit_request_generator #(
        .OUTPORTS(OUTPORTS),
        .LOCATION(LOCATION),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .req_up_i       (req_up),
        .head_up_i      (head_up),
        .tail_up_i      (tail_up),
        .dest_up_i      (dest_up),
        .ack_up_o       (ack_up_o),
        .req_dw_o       (req_dw_o),
        .ack_dw_i       (ack_dw),
        .packet_active_o(packet_active_o),
        .active_port_o  (active_port_o),
        .flit_cnt_o     (flit_cnt_o),
        .err_o          (err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ":ack_up"}, 32'(ack_up_o), 32'(e_ack_up));
        chk({tag, ":req_dw"}, 32'(req_dw_o), 32'(e_req_dw));
        chk({tag, ":active"}, 32'(packet_active_o), 32'(e_active));
        chk({tag, ":port"}, 32'(active_port_o), 32'(e_port));
        chk({tag, ":cnt"}, 32'(flit_cnt_o), 32'(e_cnt));
        chk({tag, ":err"}, 32'(err_o), 32'(e_err));
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        req_up  = 1'b0;
        head_up = 1'b0;
        tail_up = 1'b0;
        dest_up = '0;
        ack_dw  = '0;
        e_ack_up = 1'b0; e_req_dw = '0; e_active = 1'b0; e_port = '0;
        e_cnt = 0; e_err = 1'b0; m_pending = 1'b0; m_tail = 1'b0;
        tick();
        check_all("reset");
        reset = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            check_all("idle");
        end
    endtask

    task automatic send_flit(input logic h, input logic t, input logic [PW-1:0] d);
        req_up  = ~req_up;
        head_up = h;
        tail_up = t;
        dest_up = d;
        if (!e_active) begin
            if (h && int'(d) != LOCATION && int'(d) < OUTPORTS) begin
                e_active = 1'b1; e_port = d; e_cnt = 0;
                e_req_dw[d] = ~e_req_dw[d];
                m_pending = 1'b1; m_tail = t;
            end else begin
                e_ack_up = ~e_ack_up;
                e_err    = 1'b1;
            end
        end else begin
            e_req_dw[e_port] = ~e_req_dw[e_port];
            m_pending = 1'b1; m_tail = t;
            if (h) e_err = 1'b1;
        end
        tick();
        check_all("flit");
    endtask

    task automatic send_ack(input logic [OUTPORTS-1:0] mask);
        logic [OUTPORTS-1:0] expected_bit;
        logic valid;
        ack_dw = ack_dw ^ mask;
        expected_bit = m_pending ? (OUTPORTS'(1) << e_port) : '0;
        valid = |(mask & expected_bit);
        if ((mask & ~expected_bit) != '0) e_err = 1'b1;
        if (valid) begin
            e_ack_up  = ~e_ack_up;
            e_cnt     = (e_cnt < CNT_MAX) ? e_cnt + 1 : CNT_MAX;
            m_pending = 1'b0;
            if (m_tail) e_active = 1'b0;
        end
        tick();
        check_all("ack");
    endtask

    initial begin
        logic [PW-1:0]       q;
        logic [OUTPORTS-1:0] msk;
        int                  r;

        do_reset();

        // Three-flit packet to port 2, acks two cycles after each request
        send_flit(1'b1, 1'b0, 2'd2); idle(1); send_ack(4'b0100);
        send_flit(1'b0, 1'b0, 2'd0); idle(1); send_ack(4'b0100);
        send_flit(1'b0, 1'b1, 2'd3); idle(1); send_ack(4'b0100);
        chk("t1_cnt", 32'(flit_cnt_o), 32'd3);
        chk("t1_reqdw", 32'(req_dw_o), 32'b0100);
        chk("t1_active", 32'(packet_active_o), 32'd0);
        idle(2);

        // Single-flit packet to port 1
        send_flit(1'b1, 1'b1, 2'd1);
        chk("t2_active_hi", 32'(packet_active_o), 32'd1);
        idle(1); send_ack(4'b0010);
        chk("t2_cnt", 32'(flit_cnt_o), 32'd1);
        chk("t2_active_lo", 32'(packet_active_o), 32'd0);

        // U-turn head is dropped and flagged
        send_flit(1'b1, 1'b0, 2'd0);
        chk("t3_err", 32'(err_o), 32'd1);
        chk("t3_reqdw", 32'(req_dw_o), 32'b0110);
        idle(1);

        // Spurious ack on port 1 while locked to port 3
        do_reset();
        send_flit(1'b1, 1'b0, 2'd3);
        send_ack(4'b0010);
        chk("t4_err", 32'(err_o), 32'd1);
        chk("t4_noack", 32'(ack_up_o), 32'd0);
        send_ack(4'b1000);
        chk("t4_ack", 32'(ack_up_o), 32'd1);
        send_flit(1'b0, 1'b1, 2'd0);
        send_ack(4'b1001);
        chk("t4_done", 32'(packet_active_o), 32'd0);

        // Reset while a head is outstanding
        do_reset();
        send_flit(1'b1, 1'b0, 2'd2);
        do_reset();
        chk("t5_reqdw", 32'(req_dw_o), 32'd0);
        send_flit(1'b1, 1'b1, 2'd1);
        chk("t5_fwd", 32'(req_dw_o), 32'b0010);
        send_ack(4'b0010);

        // Five flits through a 2-bit saturating counter
        do_reset();
        for (int i = 0; i < 5; i++) begin
            send_flit(i == 0, i == 4, 2'd3);
            idle(1);
            send_ack(4'b1000);
            chk("t6_cnt", 32'(flit_cnt_o), 32'((i + 1 < 3) ? i + 1 : 3));
        end
        chk("t6_done", 32'(packet_active_o), 32'd0);
        chk("t6_err", 32'(err_o), 32'd0);

        // Random traffic
        do_reset();
        for (int s = 0; s < 400; s++) begin
            if ($urandom_range(0, 39) == 0) do_reset();
            idle($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (m_pending) begin
                if (r < 7) begin
                    send_ack(OUTPORTS'(1) << e_port);
                end else if (r < 9) begin
                    q = e_port + PW'($urandom_range(1, 3));
                    send_ack(OUTPORTS'(1) << q);
                end else begin
                    msk = (OUTPORTS'(1) << e_port) | OUTPORTS'($urandom_range(1, 15));
                    send_ack(msk);
                end
            end else if (r == 0) begin
                send_ack(OUTPORTS'($urandom_range(1, 15)));
            end else if (e_active) begin
                send_flit($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0,
                          PW'($urandom_range(0, 3)));
            end else begin
                send_flit($urandom_range(0, 5) != 0, $urandom_range(0, 2) == 0,
                          PW'($urandom_range(0, 3)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
